// File: rtl/ddr_burst_ctrl.sv
// Splits core DDR requests into 64-bit beats on a req/gnt bus and reassembles reads (range check: DDR_RANGE_CHECK_EN).
// Latency accept-to-done at full grant rate: single write 2, burst write 9, burst read 10 cycles.
// Backpressure: a beat holds while mem_gnt=0; ddr_ready is low while busy and requests are then dropped.
module ddr_burst_ctrl #(
  parameter int ADDR_WIDTH = 19,
  parameter int MEM_WORDS  = 524288
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ddr_chip_enable,
  input  logic [63:0]           ddr_index,
  input  logic                  ddr_write_enable,
  input  logic                  ddr_burst_mode,
  input  logic [511:0]          ddr_write_data,
  output logic [511:0]          ddr_read_data,
  output logic                  ddr_operation_done,
  output logic                  ddr_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic [63:0]           mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  ddr_range_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t                state;
  logic                  is_we;
  logic                  is_burst;
  logic [ADDR_WIDTH-1:0] base;
  logic [511:0]          wdata_q;
  logic [2:0]            issue_cnt;
  logic [3:0]            resp_cnt;

  logic [ADDR_WIDTH-1:0] acc_base;
  logic [2:0]            last_beat;
  logic [3:0]            n_beats;
  logic [2:0]            next_beat;
  logic                  gnt_fire;
  logic                  last_gnt;
  logic                  resp_fire;
  logic [3:0]            resp_cnt_nxt;
  logic                  acc_oor;
  logic [63-ADDR_WIDTH:0] unused_index;

  assign unused_index = ddr_index[63:ADDR_WIDTH];

  assign acc_base     = ddr_burst_mode ? {ddr_index[ADDR_WIDTH-1:3], 3'b000}
                                       : ddr_index[ADDR_WIDTH-1:0];
  assign last_beat    = is_burst ? 3'd7 : 3'd0;
  assign n_beats      = is_burst ? 4'd8 : 4'd1;
  assign next_beat    = issue_cnt + 3'd1;
  assign gnt_fire     = (state == ISSUE) && mem_req && mem_gnt;
  assign last_gnt     = gnt_fire && (issue_cnt == last_beat);
  // Responses are counted during ISSUE too, so early beats can return before the last grant.
  assign resp_fire    = ((state == ISSUE) || (state == RESP)) && !is_we && mem_rvalid
                        && (resp_cnt < n_beats);
  assign resp_cnt_nxt = resp_cnt + (resp_fire ? 4'd1 : 4'd0);

`ifdef DDR_RANGE_CHECK_EN
  assign acc_oor = ({{(64-ADDR_WIDTH){1'b0}}, acc_base} + (ddr_burst_mode ? 64'd7 : 64'd0))
                   >= 64'(MEM_WORDS);
`else
  localparam bit unused_mem_words = (MEM_WORDS > 0);
  assign acc_oor = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      is_we              <= 1'b0;
      is_burst           <= 1'b0;
      base               <= '0;
      wdata_q            <= '0;
      issue_cnt          <= '0;
      resp_cnt           <= '0;
      ddr_read_data      <= '0;
      ddr_operation_done <= 1'b0;
      ddr_ready          <= 1'b1;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      ddr_range_err      <= 1'b0;
    end else begin
      ddr_operation_done <= 1'b0;
      ddr_range_err      <= 1'b0;
      if (resp_fire) begin
        ddr_read_data[{resp_cnt[2:0], 6'b0} +: 64] <= mem_rdata;
        resp_cnt <= resp_cnt_nxt;
      end
      case (state)
        IDLE: begin
          if (ddr_chip_enable) begin
            is_we     <= ddr_write_enable;
            is_burst  <= ddr_burst_mode;
            base      <= acc_base;
            wdata_q   <= ddr_write_data;
            issue_cnt <= '0;
            resp_cnt  <= '0;
            ddr_ready <= 1'b0;
            if (!ddr_write_enable) ddr_read_data <= '0;
            if (acc_oor) begin
              state              <= DONE;
              ddr_operation_done <= 1'b1;
              ddr_range_err      <= 1'b1;
            end else begin
              state     <= ISSUE;
              mem_req   <= 1'b1;
              mem_we    <= ddr_write_enable;
              mem_addr  <= acc_base;
              mem_wdata <= ddr_write_data[63:0];
            end
          end
        end
        ISSUE: begin
          if (last_gnt) begin
            mem_req <= 1'b0;
            if (is_we || (resp_cnt_nxt == n_beats)) begin
              state              <= DONE;
              ddr_operation_done <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else if (gnt_fire) begin
            issue_cnt <= next_beat;
            mem_addr  <= base + ADDR_WIDTH'(next_beat);
            mem_wdata <= wdata_q[{next_beat, 6'b0} +: 64];
          end
        end
        RESP: begin
          if (resp_cnt_nxt == n_beats) begin
            state              <= DONE;
            ddr_operation_done <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ddr_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// Random and directed requests against a word-level memory model; the bench plays the memory
// slave (grant patterns, in-order delayed read returns) and predicts beats and read data per request.
module tb_ddr_burst_ctrl;

`ifdef DDR_RANGE_CHECK_EN
  localparam int unsigned TB_MEM_WORDS = 32'h100;
`else
  localparam int unsigned TB_MEM_WORDS = 32'd524288;
`endif
  localparam int unsigned AW_SPAN = 32'h80000;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ddr_chip_enable = 1'b0;
  logic [63:0]  ddr_index = '0;
  logic         ddr_write_enable = 1'b0;
  logic         ddr_burst_mode = 1'b0;
  logic [511:0] ddr_write_data = '0;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         mem_req;
  logic         mem_we;
  logic [18:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         mem_gnt = 1'b0;
  logic [63:0]  mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic         ddr_range_err;

  ddr_burst_ctrl #(.ADDR_WIDTH(19), .MEM_WORDS(TB_MEM_WORDS)) dut (
    .clock(clock), .reset(reset),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_data(ddr_write_data), .ddr_read_data(ddr_read_data),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .ddr_range_err(ddr_range_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [18:0] addr; logic we; logic [63:0] data; } beat_t;
  typedef struct { int unsigned t; logic [63:0] d; } resp_t;

  beat_t        log_q[$];
  resp_t        pend_q[$];
  logic [63:0]  mem [int unsigned];
  int           vectors = 0;
  int           miscompares = 0;
  int           gnt_mode = 0;
  int           delay_max = 0;
  int           stray_cnt = 0;
  int           stray_done = 0;
  logic [511:0] last_rd = '0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_get(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return {~a, a};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Memory slave: acts just after each falling edge, so grants and returns are stable at the rising edge.
  initial begin
    int unsigned cyc = 0;
    bit          tgl = 1'b1;
    bit          g;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        pend_q.delete();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        tgl        = 1'b1;
      end else begin
        if (stray_cnt != stray_done) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
          stray_done++;
        end else if (pend_q.size() > 0 && pend_q[0].t <= cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_q[0].d;
          void'(pend_q.pop_front());
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = 64'($urandom);
        end
        case (gnt_mode)
          0:       g = 1'b1;
          1:       begin g = tgl; tgl = ~tgl; end
          default: g = ($urandom_range(0, 9) < 6);
        endcase
        mem_gnt = g;
        if (mem_req && g) begin
          log_q.push_back('{addr: mem_addr, we: mem_we, data: mem_wdata});
          if (mem_we) mem[32'(mem_addr)] = mem_wdata;
          else pend_q.push_back('{t: cyc + 1 + 32'($urandom_range(0, delay_max)),
                                  d: mem_get(32'(mem_addr))});
        end
      end
      cyc++;
    end
  end

  task automatic do_op(input bit we, input bit burst, input logic [63:0] idx,
                       input logic [511:0] wd, input int exp_lat, input bit extra_ce);
    int unsigned  base, n, n_eff, start, waited;
    bit           oor, seen, prev_req;
    logic [18:0]  prev_addr;
    logic [511:0] exp_rd;
    beat_t        b;
    @(negedge clock);
    chk("ready_idle", ddr_ready, 1);
    base = 32'(idx[18:0]);
    if (burst) base = base / 8 * 8;
    n   = burst ? 8 : 1;
    oor = 1'b0;
`ifdef DDR_RANGE_CHECK_EN
    oor = (base + n - 1) >= TB_MEM_WORDS;
`endif
    n_eff  = oor ? 0 : n;
    exp_rd = we ? last_rd : '0;
    if (!we) for (int k = 0; k < int'(n_eff); k++)
      exp_rd[64*k +: 64] = mem_get((base + 32'(k)) % AW_SPAN);
    start = log_q.size();
    ddr_chip_enable = 1'b1; ddr_write_enable = we; ddr_burst_mode = burst;
    ddr_index = idx; ddr_write_data = wd;
    @(posedge clock);
    @(negedge clock);
    ddr_chip_enable  = 1'b0;
    ddr_index        = {$urandom, $urandom};
    ddr_write_data   = rand512();
    ddr_write_enable = 1'($urandom);
    ddr_burst_mode   = 1'($urandom);
    waited = 0; seen = 1'b0; prev_req = 1'b0; prev_addr = '0;
    while (waited < 300) begin
      if (prev_req && !mem_gnt && mem_req) chk("addr_hold", mem_addr, prev_addr);
      prev_req  = mem_req;
      prev_addr = mem_addr;
      if (ddr_operation_done) begin seen = 1'b1; break; end
      chk("ready_busy", ddr_ready, 0);
      if (extra_ce) ddr_chip_enable = (waited == 2);
      @(posedge clock);
      @(negedge clock);
      waited++;
    end
    ddr_chip_enable = 1'b0;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("range_err", ddr_range_err, oor);
      chk("beat_cnt", log_q.size() - start, n_eff);
      for (int k = 0; k < int'(n_eff) && start + k < log_q.size(); k++) begin
        b = log_q[start + k];
        chk("beat_addr", b.addr, (base + 32'(k)) % AW_SPAN);
        chk("beat_we", b.we, we);
        if (we) chk("beat_wdata", b.data, wd[64*k +: 64]);
      end
      chk("rd_data", ddr_read_data, exp_rd);
      if (exp_lat > 0 && !oor) chk("latency", waited + 1, exp_lat);
    end
    last_rd = exp_rd;
    @(negedge clock);
    chk("done_once", ddr_operation_done, 0);
    chk("ready_after", ddr_ready, 1);
    chk("err_after", ddr_range_err, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", ddr_ready, 1);
    chk("rst_done", ddr_operation_done, 0);
    chk("rst_rd", ddr_read_data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", ddr_range_err, 0);
  endtask

  initial begin
    logic [511:0] wd;
    int unsigned  start, w;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    reset = 1'b0;

    gnt_mode = 0; delay_max = 0;
    for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'(32'hA0 + k);
    do_op(1'b1, 1'b1, 64'h120, wd, 9, 1'b0);
    do_op(1'b0, 1'b1, 64'h123, '0, 10, 1'b0);

    gnt_mode = 1;
    for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'(32'h11 * (k + 1));
    do_op(1'b1, 1'b1, 64'h40, wd, 0, 1'b0);

    gnt_mode = 0;
    do_op(1'b1, 1'b0, 64'h7, {448'h0, 64'hDEADBEEF}, 2, 1'b0);
    gnt_mode = 2; delay_max = 2;
    do_op(1'b0, 1'b0, 64'hFFFF_0000_0000_0007, rand512(), 0, 1'b0);

    do_op(1'b0, 1'b1, 64'h300, '0, 0, 1'b1);
    stray_cnt++;
    repeat (4) begin
      @(negedge clock);
      chk("stray_done", ddr_operation_done, 0);
    end
    chk("stray_rd", ddr_read_data, last_rd);
    do_op(1'b1, 1'b1, 64'h308, rand512(), 0, 1'b0);

    gnt_mode = 0; delay_max = 2;
    @(negedge clock);
    start = log_q.size();
    ddr_chip_enable = 1'b1; ddr_write_enable = 1'b0; ddr_burst_mode = 1'b1; ddr_index = 64'h200;
    @(posedge clock);
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    w = 0;
    while (log_q.size() - start < 3 && w < 50) begin
      @(posedge clock);
      @(negedge clock);
      w++;
    end
    chk("rst_grants", log_q.size() - start, 3);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      chk("rst_no_done", ddr_operation_done, 0);
    end
    last_rd = '0;
    do_op(1'b0, 1'b1, 64'h200, '0, 0, 1'b0);

    gnt_mode = 0; delay_max = 0;
    do_op(1'b0, 1'b1, 64'hFC, '0, 10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] idx;
      gnt_mode  = $urandom_range(0, 2);
      delay_max = $urandom_range(0, 3);
      idx = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) idx[18:0] = 19'($urandom_range(0, 32'h3FF));
      do_op(1'($urandom), 1'($urandom), idx, rand512(), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
